// File: rtl/color_tracker_pkg.sv
// Shared types and defaults for the region colour tracker: FSM states,
// default parameter values and the region index width helper.
package color_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    SCAN    = 2'd2,
    PUBLISH = 2'd3
  } state_e;

  localparam int DEF_WIDTH         = 640;
  localparam int DEF_HEIGHT        = 480;
  localparam int DEF_NUM_REGIONS   = 4;
  localparam int DEF_THRESHOLD     = 12000;
  localparam int DEF_STABLE_FRAMES = 2;
  localparam int DEF_CNT_W         = 17;

  // Never returns zero so a region index always has at least one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/region_decoder.sv
// Maps a pixel column to its vertical strip using a compare chain against
// the strip boundaries; boundary columns belong to the strip on their right.
module region_decoder
  import color_tracker_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_REGIONS = DEF_NUM_REGIONS
) (
  input  logic [9:0]                          x,
  output logic [idx_width(NUM_REGIONS)-1:0]   index,
  output logic                                in_range
);

  localparam int IDX_W = idx_width(NUM_REGIONS);
  localparam int STRIP = WIDTH / NUM_REGIONS;

  logic [10:0] xExt;

  assign xExt     = {1'b0, x};
  assign in_range = xExt < 11'(WIDTH);

  always_comb begin
    index = '0;
    for (int k = 1; k < NUM_REGIONS; k++) begin
      if (xExt >= 11'(k * STRIP)) index = IDX_W'(k);
    end
  end

endmodule

// File: rtl/region_color_tracker.sv
// Counts matching pixels per vertical strip over a frame, scans for the
// strongest strip and publishes it once it has been stable for enough frames.
module region_color_tracker
  import color_tracker_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int HEIGHT        = DEF_HEIGHT,
  parameter int NUM_REGIONS   = DEF_NUM_REGIONS,
  parameter int THRESHOLD     = DEF_THRESHOLD,
  parameter int STABLE_FRAMES = DEF_STABLE_FRAMES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                pixel_valid,
  input  logic                                eh_verde,
  input  logic [9:0]                          x,
  input  logic [9:0]                          y,
  output logic [NUM_REGIONS-1:0]              region_hit,
  output logic [idx_width(NUM_REGIONS)-1:0]   best_region,
  output logic                                best_valid,
  output logic [CNT_W-1:0]                    best_count,
  output logic                                frame_done
);

  localparam int               IDX_W   = idx_width(NUM_REGIONS);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);
  localparam logic [3:0]       STABLE  = 4'(STABLE_FRAMES);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q [NUM_REGIONS];
  logic [CNT_W-1:0]       cnt_d [NUM_REGIONS];
  logic [IDX_W-1:0]       scanIdx_q, scanIdx_d;
  logic [CNT_W-1:0]       max_q, max_d;
  logic [IDX_W-1:0]       maxIdx_q, maxIdx_d;
  logic [NUM_REGIONS-1:0] hit_q, hit_d;
  logic [3:0]             stab_q, stab_d;
  logic                   prevValid_q, prevValid_d;
  logic [IDX_W-1:0]       prevIdx_q, prevIdx_d;
  logic [NUM_REGIONS-1:0] regionHit_q, regionHit_d;
  logic [IDX_W-1:0]       bestRegion_q, bestRegion_d;
  logic                   bestValid_q, bestValid_d;
  logic [CNT_W-1:0]       bestCount_q, bestCount_d;

  logic [IDX_W-1:0] pixIdx;
  logic             pixInX;
  logic             isFirst, isLast, hitPix;
  logic [CNT_W-1:0] scanCnt, scanMax;
  logic [IDX_W-1:0] scanMaxIdx;
  logic             takeIt;

  region_decoder #(
    .WIDTH       (WIDTH),
    .NUM_REGIONS (NUM_REGIONS)
  ) u_decoder (
    .x        (x),
    .index    (pixIdx),
    .in_range (pixInX)
  );

  assign isFirst = pixel_valid && (x == 10'd0) && (y == 10'd0);
  assign isLast  = pixel_valid && (x == 10'(WIDTH - 1)) && (y == 10'(HEIGHT - 1));
  assign hitPix  = pixel_valid && eh_verde && pixInX && ({1'b0, y} < 11'(HEIGHT));

  // Running maximum; strict greater-than keeps the lowest index on ties.
  assign scanCnt    = cnt_q[scanIdx_q];
  assign takeIt     = (scanIdx_q == '0) || (scanCnt > max_q);
  assign scanMax    = takeIt ? scanCnt : max_q;
  assign scanMaxIdx = takeIt ? scanIdx_q : maxIdx_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    scanIdx_d    = scanIdx_q;
    max_d        = max_q;
    maxIdx_d     = maxIdx_q;
    hit_d        = hit_q;
    stab_d       = stab_q;
    prevValid_d  = prevValid_q;
    prevIdx_d    = prevIdx_q;
    regionHit_d  = regionHit_q;
    bestRegion_d = bestRegion_q;
    bestValid_d  = bestValid_q;
    bestCount_d  = bestCount_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (isFirst) begin
          for (int i = 0; i < NUM_REGIONS; i++) cnt_d[i] = '0;
        end
        if ((state_q == ACCUM || isFirst) && hitPix && cnt_d[pixIdx] != CNT_MAX) begin
          cnt_d[pixIdx] = cnt_d[pixIdx] + CNT_W'(1);
        end
        if (isFirst) begin
          state_d = ACCUM;
        end else if (state_q == ACCUM && isLast) begin
          state_d   = SCAN;
          scanIdx_d = '0;
        end
      end

      SCAN: begin
        max_d            = scanMax;
        maxIdx_d         = scanMaxIdx;
        hit_d[scanIdx_q] = scanCnt > THR;
        scanIdx_d        = scanIdx_q + IDX_W'(1);
        // Results are registered on the way into PUBLISH so they are
        // visible in the same cycle frame_done pulses.
        if (scanIdx_q == IDX_W'(NUM_REGIONS - 1)) begin
          state_d     = PUBLISH;
          regionHit_d = hit_d;
          bestCount_d = scanMax;
          if (scanMax > THR) begin
            if (prevValid_q && prevIdx_q == scanMaxIdx) begin
              stab_d = (stab_q >= STABLE) ? STABLE : stab_q + 4'd1;
            end else begin
              stab_d = 4'd1;
            end
            prevValid_d = 1'b1;
            prevIdx_d   = scanMaxIdx;
            if (stab_d == STABLE) begin
              bestRegion_d = scanMaxIdx;
              bestValid_d  = 1'b1;
            end
          end else begin
            stab_d      = 4'd0;
            prevValid_d = 1'b0;
            bestValid_d = 1'b0;
          end
        end
      end

      PUBLISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_q      <= IDLE;
      for (int i = 0; i < NUM_REGIONS; i++) cnt_q[i] <= '0;
      scanIdx_q    <= '0;
      max_q        <= '0;
      maxIdx_q     <= '0;
      hit_q        <= '0;
      stab_q       <= '0;
      prevValid_q  <= 1'b0;
      prevIdx_q    <= '0;
      regionHit_q  <= '0;
      bestRegion_q <= '0;
      bestValid_q  <= 1'b0;
      bestCount_q  <= '0;
    end else begin
      state_q      <= state_d;
      for (int i = 0; i < NUM_REGIONS; i++) cnt_q[i] <= cnt_d[i];
      scanIdx_q    <= scanIdx_d;
      max_q        <= max_d;
      maxIdx_q     <= maxIdx_d;
      hit_q        <= hit_d;
      stab_q       <= stab_d;
      prevValid_q  <= prevValid_d;
      prevIdx_q    <= prevIdx_d;
      regionHit_q  <= regionHit_d;
      bestRegion_q <= bestRegion_d;
      bestValid_q  <= bestValid_d;
      bestCount_q  <= bestCount_d;
    end
  end

  assign region_hit  = regionHit_q;
  assign best_region = bestRegion_q;
  assign best_valid  = bestValid_q;
  assign best_count  = bestCount_q;
  assign frame_done  = (state_q == PUBLISH);

endmodule

// File: tb/tb_region_color_tracker.sv
// Directed bench on a scaled-down 16x8 frame with four 4-column strips; each
// frame lights the first N pixels (row-major within a strip) of every strip.
module tb_region_color_tracker;

  localparam int W      = 16;
  localparam int H      = 8;
  localparam int N      = 4;
  localparam int THRESH = 10;
  localparam int STABLE = 2;
  localparam int CW     = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          pixel_valid;
  logic          eh_verde;
  logic [9:0]    x;
  logic [9:0]    y;
  logic [N-1:0]  region_hit;
  logic [1:0]    best_region;
  logic          best_valid;
  logic [CW-1:0] best_count;
  logic          frame_done;

  int assertCount = 0;
  int failCount   = 0;
  int doneCount   = 0;
  int lat;
  int doneBefore;

  region_color_tracker #(
    .WIDTH         (W),
    .HEIGHT        (H),
    .NUM_REGIONS   (N),
    .THRESHOLD     (THRESH),
    .STABLE_FRAMES (STABLE),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pixel_valid (pixel_valid),
    .eh_verde    (eh_verde),
    .x           (x),
    .y           (y),
    .region_hit  (region_hit),
    .best_region (best_region),
    .best_valid  (best_valid),
    .best_count  (best_count),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) doneCount++;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives rows rowStart..rowEnd in raster order; strip r pixel is green when
  // its ordinal (row*4 + column within strip) is below hN.
  task automatic applyStimulus(input int h0, input int h1, input int h2, input int h3,
                               input int rowStart, input int rowEnd);
    int hits[4];
    hits = '{h0, h1, h2, h3};
    for (int yy = rowStart; yy <= rowEnd; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        @(negedge clk);
        pixel_valid = 1'b1;
        x           = 10'(xx);
        y           = 10'(yy);
        eh_verde    = ((yy * 4 + xx % 4) < hits[xx / 4]);
      end
    end
  endtask

  task automatic waitFrameDone(output int latency);
    latency = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        pixel_valid = 1'b0;
        eh_verde    = 1'b0;
      end
      if (frame_done) begin
        latency = i;
        break;
      end
    end
  endtask

  task automatic checkFrame(input string tag, input int expHit, input int expCount,
                            input int expValid, input int expRegion);
    waitFrameDone(lat);
    checkOutput({tag, " latency"}, lat, N + 1);
    checkOutput({tag, " region_hit"}, region_hit, expHit);
    checkOutput({tag, " best_count"}, best_count, expCount);
    checkOutput({tag, " best_valid"}, best_valid, expValid);
    checkOutput({tag, " best_region"}, best_region, expRegion);
    @(negedge clk);
    checkOutput({tag, " pulse width"}, frame_done, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " region_hit"}, region_hit, 0);
    checkOutput({tag, " best_count"}, best_count, 0);
    checkOutput({tag, " best_valid"}, best_valid, 0);
    checkOutput({tag, " best_region"}, best_region, 0);
    checkOutput({tag, " frame_done"}, frame_done, 0);
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    pixel_valid = 1'b0;
    eh_verde    = 1'b0;
    x           = '0;
    y           = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkAllZero("reset");

    // Uniform strip 2 must persist two frames before publishing.
    applyStimulus(0, 0, 20, 0, 0, H - 1);
    checkFrame("uniform1", 4'b0100, 20, 0, 0);
    applyStimulus(0, 0, 20, 0, 0, H - 1);
    checkFrame("uniform2", 4'b0100, 20, 1, 2);

    // Tie between strips 1 and 3: lowest index wins.
    applyStimulus(0, 15, 0, 15, 0, H - 1);
    checkFrame("tie1", 4'b1010, 15, 1, 2);
    applyStimulus(0, 15, 0, 15, 0, H - 1);
    checkFrame("tie2", 4'b1010, 15, 1, 1);

    // Exactly at threshold is not a detection; one more is.
    applyStimulus(10, 0, 0, 0, 0, H - 1);
    checkFrame("thr_eq", 4'b0000, 10, 0, 1);
    applyStimulus(11, 0, 0, 0, 0, H - 1);
    checkFrame("thr_gt", 4'b0001, 11, 0, 1);

    // 32 hits in a 5-bit counter saturate at 31.
    applyStimulus(32, 0, 0, 0, 0, H - 1);
    checkFrame("saturate", 4'b0001, 31, 1, 0);

    // Reset mid-frame; the remainder (including the last pixel) is ignored.
    doneBefore = doneCount;
    applyStimulus(0, 0, 20, 0, 0, 3);
    @(negedge clk);
    pixel_valid = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkAllZero("midreset");
    applyStimulus(0, 0, 20, 0, 4, H - 1);
    @(negedge clk);
    pixel_valid = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("midreset no done", doneCount, doneBefore);
    checkOutput("midreset hit idle", region_hit, 0);
    applyStimulus(0, 0, 20, 0, 0, H - 1);
    checkFrame("after_reset", 4'b0100, 20, 0, 0);

    // Disable acts as reset.
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    checkAllZero("disable");

    // Alternating winners never become stable.
    applyStimulus(20, 0, 0, 0, 0, H - 1);
    checkFrame("alt1", 4'b0001, 20, 0, 0);
    applyStimulus(0, 0, 0, 20, 0, H - 1);
    checkFrame("alt2", 4'b1000, 20, 0, 0);
    applyStimulus(20, 0, 0, 0, 0, H - 1);
    checkFrame("alt3", 4'b0001, 20, 0, 0);

    // A new (0,0) mid-frame restarts counting without publishing.
    doneBefore = doneCount;
    applyStimulus(0, 0, 0, 32, 0, 3);
    checkOutput("restart no done", doneCount, doneBefore);
    applyStimulus(0, 20, 0, 0, 0, H - 1);
    checkFrame("restart", 4'b0010, 20, 0, 0);
    checkOutput("restart one done", doneCount, doneBefore + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
